// File: rtl/cache02_data_wrapper.sv
// ----------------------------------------------------------------------------
// cache02_data_wrapper
// 256 x 32-bit backing data memory fronted by a 16-line direct-mapped cache
// with one word per line. Reads are zero-latency: a hit returns the cached
// word and a miss returns the memory word in the same cycle, while the line
// is filled at the next rising edge. Writes are write-through and
// write-allocate, so the cache never holds data that differs from memory.
// ----------------------------------------------------------------------------
module cache02_data_wrapper (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic        MemWrite,
    input  logic [31:0] WD,
    output logic [31:0] DataMemRead,
    output logic        hit
);

    localparam int MEM_WORDS = 256;
    localparam int LINES     = 16;
    localparam int TAG_W     = 26;

    // Storage: backing memory, cache data/tag arrays and per-line valid bits
    logic [31:0]      r_mem   [0:MEM_WORDS-1];
    logic [31:0]      r_data  [0:LINES-1];
    logic [TAG_W-1:0] r_tag   [0:LINES-1];
    logic [LINES-1:0] r_valid;

    // Address decode: memory word index, cache line index and tag
    logic [7:0]       w_mem_idx;
    logic [3:0]       w_line;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_mem_word;
    logic             w_fill;
    logic [31:0]      w_fill_data;
    logic             w_unused;

    assign w_mem_idx  = A[9:2];
    assign w_line     = A[5:2];
    assign w_tag      = A[31:6];
    assign w_mem_word = r_mem[w_mem_idx];

    // Byte offset is irrelevant for word-aligned accesses.
    assign w_unused = ^A[1:0];

    // A line is looked up combinationally for reads and writes alike.
    assign hit = r_valid[w_line] && (r_tag[w_line] == w_tag);

    // Before a write edge this still shows the pre-write contents.
    assign DataMemRead = hit ? r_data[w_line] : w_mem_word;

    // Every write allocates; a read allocates only when it misses.
    assign w_fill      = MemWrite || !hit;
    assign w_fill_data = MemWrite ? WD : w_mem_word;

    // Backing memory write port; contents survive reset
    // NOTE: memory arrays get no reset branch; clearing them would force
    // flops instead of RAM, and their contents must outlive rst_n anyway.
    always_ff @(posedge clk) begin
        if (rst_n && MemWrite) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_mem[w_mem_idx] <= WD;
        end
    end

    // Cache line data and tag update on fill or write-allocate
    always_ff @(posedge clk) begin
        if (rst_n && w_fill) begin
            r_data[w_line] <= w_fill_data;
            r_tag[w_line]  <= w_tag;
        end
    end

    // Valid bits: cleared asynchronously by reset, set on every allocation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_line] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache02_data_wrapper.sv
// ----------------------------------------------------------------------------
// tb_cache02_data_wrapper
// Scoreboard bench: the stimulus process drives a new address every half
// period and pushes the expected hit/read data from a reference model; an
// independent monitor pops and compares shortly after each drive.
// The model keeps memory as a plain word array and the cache as a table of
// which address occupies each line; read data is always the memory word
// because a write-through cache can never disagree with memory.
// ----------------------------------------------------------------------------
module tb_cache02_data_wrapper;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic        MemWrite;
    logic [31:0] WD;
    logic [31:0] DataMemRead;
    logic        hit;

    cache02_data_wrapper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .MemWrite   (MemWrite),
        .WD         (WD),
        .DataMemRead(DataMemRead),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    event        ev_sample;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: memory words plus which word address each line holds.
    logic [31:0] m_mem      [0:255];
    logic [29:0] m_line_addr[0:15];
    bit          m_line_vld [0:15];

    function automatic bit model_hit(input logic [31:0] a);
        int line;
        line = int'(a[5:2]);
        return m_line_vld[line] && (m_line_addr[line][29:4] == a[31:6]);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_line_vld[i] = 1'b0;
    endfunction

    // Effect of one rising edge taken with the access (a, we, wd).
    function automatic void model_edge(input logic [31:0] a, input logic we,
                                       input logic [31:0] wd);
        int line;
        line = int'(a[5:2]);
        if (we) m_mem[int'(a[9:2])] = wd;
        if (we || !model_hit(a)) begin
            m_line_vld[line]  = 1'b1;
            m_line_addr[line] = a[31:2];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one half-period access, publish its expectation, then follow
    // the next clock edge and apply its effect to the model.
    task automatic drive_half(input logic [31:0] a, input logic we,
                              input logic [31:0] wd, input string name);
        exp_t e;
        A        = a;
        MemWrite = we;
        WD       = wd;
        e.hit    = rst_n && model_hit(a);
        e.data   = m_mem[int'(a[9:2])];
        e.name   = name;
        exp_q.push_back(e);
        -> ev_sample;
        @(clk);
        if (clk === 1'b1 && rst_n === 1'b1) model_edge(a, we, wd);
        #1;
    endtask

    // Two half periods always span exactly one rising edge.
    task automatic cycle(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input string name);
        drive_half(a, we, wd, name);
        drive_half(a, we, wd, name);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_clear();
    endtask

    // Monitor: compare outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_hit"},  {31'd0, hit}, {31'd0, e.hit});
                check({e.name, "_data"}, DataMemRead, e.data);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic        we;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) m_line_addr[i] = '0;
        model_clear();
        rst_n    = 1'b0;
        A        = 32'd0;
        MemWrite = 1'b0;
        WD       = 32'd0;
        #1;

        // Held in reset: outputs defined, and a store must be ignored.
        drive_half(32'h0, 1'b0, 32'h0, "in_reset_rd");
        cycle(32'h8, 1'b1, 32'h0000_1234, "in_reset_wr");
        rst_n = 1'b1;

        // Cold read of 0x0, then hit after one edge.
        drive_half(32'h0, 1'b0, 32'h0, "cold_a0");
        cycle(32'h0, 1'b0, 32'h0, "fill_a0");
        cycle(32'h8, 1'b0, 32'h0, "ignored_wr_a8");

        // Write then read back, then conflicting index eviction.
        cycle(32'h10, 1'b1, 32'hDEAD_BEEF, "wr_a10");
        cycle(32'h10, 1'b0, 32'h0, "rd_a10");
        cycle(32'h50, 1'b0, 32'h0, "conflict_a50");
        cycle(32'h10, 1'b0, 32'h0, "evicted_a10");

        // Aliasing: 0x420 shares memory word 8 with 0x20 but not its tag.
        cycle(32'h20, 1'b0, 32'h0, "alias_rd_a20");
        cycle(32'h420, 1'b1, 32'hA5A5_0420, "alias_wr_a420");
        cycle(32'h20, 1'b0, 32'h0, "alias_rd_a20_after");
        cycle(32'hFFFF_FFC4, 1'b0, 32'h0, "high_tag_rd");

        // Half-period sweep with an asynchronous reset in the middle.
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                assert_reset();
                drive_half(i * 4, 1'b0, 32'h0, "sweep_rst_rd");
                drive_half(32'h10, 1'b1, 32'h0BAD_0BAD, "sweep_rst_wr");
                drive_half(32'h10, 1'b1, 32'h0BAD_0BAD, "sweep_rst_wr");
                rst_n = 1'b1;
                drive_half(32'h10, 1'b0, 32'h0, "post_rst_a10");
            end
            drive_half(i * 4, 1'b0, 32'h0, "sweep");
        end

        // Randomized mix of reads and writes over a small address window.
        for (int i = 0; i < 400; i++) begin
            a  = 32'($urandom_range(0, 59)) * 4;
            we = ($urandom_range(0, 9) < 3);
            drive_half(a, we, $urandom, "random");
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
